csr_trap_unit: RTL and testbench
================================

// Module: csr_trap_unit
// PURPOSE
//  Machine-mode CSR file and trap-state sequencer for the RV32 core. It sits
//  downstream of the exception unit: on a raised exception/interrupt it latches
//  mepc/mcause and stacks mstatus.MIE. It returns interrupt_en, mtvec_mode and
//  mtvec_base to that unit, serves Zicsr accesses from the pipeline, executes
//  MRET, and keeps the 64-bit mcycle/minstret counters.
// PARAMETERS
//  HART_ID      32'h0000_0000  value returned by mhartid (0xF14)
//  RESET_MTVEC  32'h0000_0000  mtvec reset value; [1:0] must be 2'b00 or 2'b01
// PORTS
//  CLK              in   1   core clock, all state updates on rising edge
//  nRST             in   1   asynchronous active-low reset
//  csr_op           in   2   00 none, 01 RW, 10 RS (set), 11 RC (clear)
//  csr_addr         in   12  CSR address
//  csr_wdata        in   32  rs1/zimm operand
//  csr_rdata        out  32  current (pre-write) value of csr_addr, combinational
//  csr_illegal      out  1   unimplemented addr, or write to read-only addr
//  exception        in   1   trap request from exception unit
//  is_interrupt     in   1   1: interrupt, 0: exception
//  exception_pc     in   32  PC to save in mepc
//  exception_cause  in   32  cause code; [30:0] used
//  mret             in   1   MRET retiring this cycle
//  retire           in   1   one instruction retires this cycle
//  mepc_out         out  32  current mepc (MRET target)
//  interrupt_en     out  1   mstatus.MIE
//  mtvec_mode       out  2   mtvec[1:0]
//  mtvec_base       out  32  {mtvec[31:2],2'b00}
// BEHAVIOUR
//  Implemented CSRs: mstatus 0x300, misa 0x301 (RO, 32'h4000_0100), mtvec 0x305,
//   mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80,
//   minstret 0xB02, minstreth 0xB82, mhartid 0xF14 (RO). Other addr -> rdata 0.
//  Reset: mstatus MIE=0, MPIE=0, MPP=2'b11; mtvec=RESET_MTVEC; mscratch, mepc,
//   mcause, mcycle, minstret = 0. Outputs follow: interrupt_en=0, mepc_out=0.
//  mstatus: only MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11; others read 0.
//  Write value: RW=wdata; RS=old|wdata; RC=old&~wdata; takes effect next edge.
//  csr_illegal=1 when csr_op!=0 and (addr unimplemented or (addr[11:10]==2'b11
//   and op writes)); no state changes then. RS/RC to RO addr with wdata==0 legal.
//  mtvec write: base [31:2] always written; mode written only if new mode is 0/1,
//   else old mode kept (WARL). mepc write forces [1:0]=0.
//  Priority per cycle: exception > mret > CSR write. Trap edge: mepc <=
//   {exception_pc[31:2],2'b00}; mcause <= {is_interrupt,exception_cause[30:0]};
//   MPIE <= MIE; MIE <= 0; any same-cycle CSR write/mret is dropped.
//  MRET edge (no exception): MIE <= MPIE; MPIE <= 1; same-cycle CSR write dropped.
//  Counters: mcycle +1 every cycle; minstret +1 when retire. 64-bit, carry from
//   low into high half; 2^64-1 wraps to 0. CSR write to a half replaces that half
//   for the cycle (no increment); other half still receives carry-free old value.
//   A write dropped by exception/mret lets the increment occur normally.
//  No pipeline latency beyond one edge: values written in cycle N read in N+1.
// TESTING
//  1 Reset mid-run (nRST low with mcycle=0x1234) -> all CSRs at reset values
//    immediately, interrupt_en=0, mtvec_base=RESET_MTVEC.
//  2 RW 0x300 wdata=0x88; exception pc=0x8000_0106 cause=2 -> next cycle
//    mepc=0x8000_0104, mcause=2, MIE=0, MPIE=1; mret -> MIE=1, MPIE=1.
//  3 RW 0x305 0x2000_0003 -> base 0x2000_0000, mode unchanged (0); RS 0x305 1 ->
//    mode 1; RC mscratch 0xF0 after RW 0xFF -> 0x0F.
//  4 Same-cycle exception + RW mscratch 0x55 + mret -> mscratch unchanged, trap
//    state updated, MRET ignored.
//  5 RW mcycle 0xFFFF_FFFF, mcycleh 0 -> after 2 cycles mcycleh=1, mcycle=0;
//    minstret at 2^64-1 + retire -> 0.
//  6 RW 0xF14 / access 0x7C0 -> csr_illegal=1, no state change; RS 0xF14 with
//    wdata=0 -> rdata=HART_ID, csr_illegal=0.

Source files
------------

// File: rtl/csr_trap_unit.sv
// ============================================================================
// csr_trap_unit
// ----------------------------------------------------------------------------
// Machine-mode CSR file and trap-state sequencer for an RV32 core.
//  - Serves Zicsr RW/RS/RC accesses (read data is combinational, pre-write).
//  - On a trap latches mepc/mcause and stacks mstatus.MIE into MPIE.
//  - Executes MRET (MIE <= MPIE, MPIE <= 1).
//  - Keeps the 64-bit mcycle / minstret counters.
//
// Ports
//  CLK, nRST        clock, asynchronous active-low reset
//  csr_op           00 none, 01 RW, 10 RS, 11 RC
//  csr_addr         12-bit CSR address
//  csr_wdata        rs1/zimm operand
//  csr_rdata        current value of csr_addr (combinational)
//  csr_illegal      unimplemented address or write to a read-only address
//  exception        trap request, with is_interrupt/exception_pc/exception_cause
//  mret             MRET retiring this cycle
//  retire           one instruction retires this cycle
//  mepc_out         current mepc (MRET target)
//  interrupt_en     mstatus.MIE
//  mtvec_mode       mtvec[1:0]
//  mtvec_base       {mtvec[31:2], 2'b00}
// ============================================================================
module csr_trap_unit #(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        exception,
    input  logic        is_interrupt,
    input  logic [31:0] exception_pc,
    input  logic [31:0] exception_cause,
    input  logic        mret,
    input  logic        retire,
    output logic [31:0] mepc_out,
    output logic        interrupt_en,
    output logic [1:0]  mtvec_mode,
    output logic [31:0] mtvec_base
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 64;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MISA_VAL = 32'h4000_0100;

    // Architectural state
    logic            mie_q;
    logic            mpie_q;
    logic [XLEN-3:0] mtvec_base_q;
    logic [1:0]      mtvec_mode_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [CW-1:0]   mcycle_q;
    logic [CW-1:0]   minstret_q;

    // Access decode
    logic            addr_valid;
    logic            op_writes;
    logic            csr_we;
    logic [XLEN-1:0] wval;
    logic [XLEN-1:0] mstatus_rd;
    logic [CW-1:0]   mcycle_d;
    logic [CW-1:0]   minstret_d;

    // Cause bit 31 is replaced by is_interrupt; PC low bits are forced to zero.
    logic unused_inputs;
    assign unused_inputs = ^{exception_cause[31], exception_pc[1:0]};

    // mstatus view: MPP hardwired to M-mode, only MIE/MPIE stored.
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

    // Read mux and implemented-address decode.
    always_comb begin
        addr_valid = 1'b1;
        csr_rdata  = '0;
        case (csr_addr)
            ADDR_MSTATUS:   csr_rdata = mstatus_rd;
            ADDR_MISA:      csr_rdata = MISA_VAL;
            ADDR_MTVEC:     csr_rdata = {mtvec_base_q, mtvec_mode_q};
            ADDR_MSCRATCH:  csr_rdata = mscratch_q;
            ADDR_MEPC:      csr_rdata = mepc_q;
            ADDR_MCAUSE:    csr_rdata = mcause_q;
            ADDR_MCYCLE:    csr_rdata = mcycle_q[XLEN-1:0];
            ADDR_MCYCLEH:   csr_rdata = mcycle_q[CW-1:XLEN];
            ADDR_MINSTRET:  csr_rdata = minstret_q[XLEN-1:0];
            ADDR_MINSTRETH: csr_rdata = minstret_q[CW-1:XLEN];
            ADDR_MHARTID:   csr_rdata = HART_ID;
            default: begin
                addr_valid = 1'b0;
                csr_rdata  = '0;
            end
        endcase
    end

    // RS/RC with a zero operand is a pure read and never modifies state.
    always_comb begin
        op_writes   = (csr_op == OP_RW) ||
                      ((csr_op != OP_NONE) && (csr_wdata != '0));
        csr_illegal = (csr_op != OP_NONE) &&
                      (!addr_valid || ((csr_addr[11:10] == 2'b11) && op_writes));
        // Trap and MRET both take priority over the CSR write.
        csr_we      = op_writes && !csr_illegal && !exception && !mret;
    end

    // New value for the addressed CSR.
    always_comb begin
        wval = csr_wdata;
        case (csr_op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = csr_rdata | csr_wdata;
            OP_RC:   wval = csr_rdata & ~csr_wdata;
            default: wval = csr_rdata;
        endcase
    end

    // Counter next values: a written half freezes the whole counter that cycle.
    always_comb begin
        mcycle_d   = mcycle_q + CW'(1);
        minstret_d = minstret_q + CW'(retire);
        if (csr_we && (csr_addr == ADDR_MCYCLE)) begin
            mcycle_d = {mcycle_q[CW-1:XLEN], wval};
        end else if (csr_we && (csr_addr == ADDR_MCYCLEH)) begin
            mcycle_d = {wval, mcycle_q[XLEN-1:0]};
        end
        if (csr_we && (csr_addr == ADDR_MINSTRET)) begin
            minstret_d = {minstret_q[CW-1:XLEN], wval};
        end else if (csr_we && (csr_addr == ADDR_MINSTRETH)) begin
            minstret_d = {wval, minstret_q[XLEN-1:0]};
        end
    end

    // Trap / MRET / CSR-write state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            mtvec_base_q <= RESET_MTVEC[XLEN-1:2];
            mtvec_mode_q <= RESET_MTVEC[1:0];
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            if (exception) begin
                mepc_q   <= {exception_pc[XLEN-1:2], 2'b00};
                mcause_q <= {is_interrupt, exception_cause[XLEN-2:0]};
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret) begin
                mie_q    <= mpie_q;
                mpie_q   <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        mie_q  <= wval[3];
                        mpie_q <= wval[7];
                    end
                    ADDR_MTVEC: begin
                        mtvec_base_q <= wval[XLEN-1:2];
                        // WARL: only direct (0) and vectored (1) modes accepted.
                        if (!wval[1]) begin
                            mtvec_mode_q <= wval[1:0];
                        end
                    end
                    ADDR_MSCRATCH: mscratch_q <= wval;
                    ADDR_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE:   mcause_q   <= wval;
                    default: ;
                endcase
            end
        end
    end

    // 64-bit counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mepc_out     = mepc_q;
    assign interrupt_en = mie_q;
    assign mtvec_mode   = mtvec_mode_q;
    assign mtvec_base   = {mtvec_base_q, 2'b00};

endmodule

// File: tb/tb_csr_trap_unit.sv
// ============================================================================
// tb_csr_trap_unit
// ----------------------------------------------------------------------------
// Directed bench for csr_trap_unit: a table of CSR accesses with expected
// pre-write read data and illegal flag, plus hand-written sequences for reset,
// trap/MRET priority and counter carry/wrap.
// ============================================================================
module tb_csr_trap_unit;

    localparam logic [31:0] HART = 32'h0000_0005;
    localparam logic [31:0] RMTV = 32'h0000_1000;

    logic        CLK;
    logic        nRST;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        exception;
    logic        is_interrupt;
    logic [31:0] exception_pc;
    logic [31:0] exception_cause;
    logic        mret;
    logic        retire;
    logic [31:0] mepc_out;
    logic        interrupt_en;
    logic [1:0]  mtvec_mode;
    logic [31:0] mtvec_base;

    int checks;
    int failures;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    localparam int unsigned NVEC = 26;
    vec_t vecs [NVEC];

    csr_trap_unit #(.HART_ID(HART), .RESET_MTVEC(RMTV)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .csr_op          (csr_op),
        .csr_addr        (csr_addr),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata),
        .csr_illegal     (csr_illegal),
        .exception       (exception),
        .is_interrupt    (is_interrupt),
        .exception_pc    (exception_pc),
        .exception_cause (exception_cause),
        .mret            (mret),
        .retire          (retire),
        .mepc_out        (mepc_out),
        .interrupt_en    (interrupt_en),
        .mtvec_mode      (mtvec_mode),
        .mtvec_base      (mtvec_base)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wdata;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Combinational read of an address with no access in flight.
    task automatic read_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        drive(2'b00, addr, 32'h0);
        #1;
        check(name, csr_rdata, exp);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        nRST         = 1'b0;
        exception    = 1'b0;
        is_interrupt = 1'b0;
        exception_pc = '0;
        exception_cause = '0;
        mret         = 1'b0;
        retire       = 1'b0;
        drive(2'b00, 12'h000, 32'h0);

        // op, addr, wdata, expected pre-write rdata, expected illegal
        vecs[0]  = '{2'b01, 12'h300, 32'h0000_0088, 32'h0000_1800, 1'b0};
        vecs[1]  = '{2'b10, 12'h300, 32'h0000_0000, 32'h0000_1888, 1'b0};
        vecs[2]  = '{2'b11, 12'h300, 32'h0000_0008, 32'h0000_1888, 1'b0};
        vecs[3]  = '{2'b10, 12'h300, 32'h0000_0000, 32'h0000_1880, 1'b0};
        vecs[4]  = '{2'b01, 12'h301, 32'h0000_0000, 32'h4000_0100, 1'b0};
        vecs[5]  = '{2'b10, 12'h301, 32'h0000_0000, 32'h4000_0100, 1'b0};
        vecs[6]  = '{2'b01, 12'h305, 32'h2000_0003, 32'h0000_1000, 1'b0};
        vecs[7]  = '{2'b10, 12'h305, 32'h0000_0001, 32'h2000_0000, 1'b0};
        vecs[8]  = '{2'b10, 12'h305, 32'h0000_0000, 32'h2000_0001, 1'b0};
        vecs[9]  = '{2'b01, 12'h305, 32'h3000_0002, 32'h2000_0001, 1'b0};
        vecs[10] = '{2'b10, 12'h305, 32'h0000_0000, 32'h3000_0001, 1'b0};
        vecs[11] = '{2'b01, 12'h340, 32'h0000_00FF, 32'h0000_0000, 1'b0};
        vecs[12] = '{2'b11, 12'h340, 32'h0000_00F0, 32'h0000_00FF, 1'b0};
        vecs[13] = '{2'b10, 12'h340, 32'h0000_0000, 32'h0000_000F, 1'b0};
        vecs[14] = '{2'b01, 12'h341, 32'h1234_5677, 32'h0000_0000, 1'b0};
        vecs[15] = '{2'b10, 12'h341, 32'h0000_0000, 32'h1234_5674, 1'b0};
        vecs[16] = '{2'b01, 12'h342, 32'h8000_000B, 32'h0000_0000, 1'b0};
        vecs[17] = '{2'b10, 12'h342, 32'h0000_0000, 32'h8000_000B, 1'b0};
        vecs[18] = '{2'b01, 12'hF14, 32'h0000_0001, HART,          1'b1};
        vecs[19] = '{2'b10, 12'hF14, 32'h0000_0000, HART,          1'b0};
        vecs[20] = '{2'b11, 12'hF14, 32'h0000_0001, HART,          1'b1};
        vecs[21] = '{2'b01, 12'h7C0, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[22] = '{2'b10, 12'h7C0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[23] = '{2'b00, 12'h7C0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[24] = '{2'b10, 12'h340, 32'h0000_0000, 32'h0000_000F, 1'b0};
        vecs[25] = '{2'b01, 12'h300, 32'h0000_0000, 32'h0000_1880, 1'b0};

        // ---- Power-on reset values ----
        #12;
        nRST = 1'b1;
        tick();
        check("rst_interrupt_en", 32'(interrupt_en), 32'h0);
        check("rst_mepc_out", mepc_out, 32'h0);
        check("rst_mtvec_base", mtvec_base, RMTV);
        read_chk("rst_mstatus", 12'h300, 32'h0000_1800);

        // ---- Reset mid-run ----
        drive(2'b01, 12'h300, 32'h0000_0008); tick();
        drive(2'b01, 12'h341, 32'h0000_0100); tick();
        drive(2'b01, 12'hB00, 32'h0000_1234); tick();
        read_chk("pre_rst_mcycle", 12'hB00, 32'h0000_1234);
        check("pre_rst_interrupt_en", 32'(interrupt_en), 32'h1);
        check("pre_rst_mepc_out", mepc_out, 32'h0000_0100);
        nRST = 1'b0;
        #1;
        check("midrst_mcycle", csr_rdata, 32'h0);
        check("midrst_interrupt_en", 32'(interrupt_en), 32'h0);
        check("midrst_mepc_out", mepc_out, 32'h0);
        check("midrst_mtvec_base", mtvec_base, RMTV);
        check("midrst_mtvec_mode", 32'(mtvec_mode), 32'h0);
        read_chk("midrst_mstatus", 12'h300, 32'h0000_1800);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // ---- Table of CSR accesses ----
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            #1;
            check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_illegal", i), 32'(csr_illegal), 32'(vecs[i].exp_ill));
            tick();
        end
        check("tbl_mtvec_base", mtvec_base, 32'h3000_0000);
        check("tbl_mtvec_mode", 32'(mtvec_mode), 32'h1);
        check("tbl_mepc_out", mepc_out, 32'h1234_5674);

        // ---- Trap then MRET ----
        drive(2'b01, 12'h300, 32'h0000_0088); tick();
        drive(2'b00, 12'h000, 32'h0);
        exception       = 1'b1;
        is_interrupt    = 1'b0;
        exception_pc    = 32'h8000_0106;
        exception_cause = 32'h0000_0002;
        tick();
        exception = 1'b0;
        check("trap_mepc_out", mepc_out, 32'h8000_0104);
        check("trap_interrupt_en", 32'(interrupt_en), 32'h0);
        read_chk("trap_mcause", 12'h342, 32'h0000_0002);
        read_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("mret_interrupt_en", 32'(interrupt_en), 32'h1);
        read_chk("mret_mstatus", 12'h300, 32'h0000_1888);

        // ---- Exception + CSR write + MRET in one cycle ----
        drive(2'b01, 12'h340, 32'h0000_0055);
        exception       = 1'b1;
        is_interrupt    = 1'b1;
        exception_pc    = 32'h0000_2003;
        exception_cause = 32'hFFFF_FFF7;
        mret            = 1'b1;
        tick();
        exception = 1'b0;
        mret      = 1'b0;
        read_chk("prio_mscratch", 12'h340, 32'h0000_000F);
        read_chk("prio_mcause", 12'h342, 32'hFFFF_FFF7);
        read_chk("prio_mstatus", 12'h300, 32'h0000_1880);
        check("prio_mepc_out", mepc_out, 32'h0000_2000);
        check("prio_interrupt_en", 32'(interrupt_en), 32'h0);

        // ---- MRET drops a same-cycle CSR write ----
        drive(2'b01, 12'h340, 32'h0000_0077);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        read_chk("mretw_mscratch", 12'h340, 32'h0000_000F);
        read_chk("mretw_mstatus", 12'h300, 32'h0000_1888);

        // ---- Illegal write leaves state alone ----
        drive(2'b01, 12'hF14, 32'h0000_00AA); tick();
        read_chk("ill_mhartid", 12'hF14, HART);

        // ---- mcycle carry from low to high half ----
        drive(2'b01, 12'hB80, 32'h0000_0000); tick();
        drive(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
        read_chk("cyc_lo_pre", 12'hB00, 32'hFFFF_FFFF);
        read_chk("cyc_hi_pre", 12'hB80, 32'h0000_0000);
        tick();
        read_chk("cyc_lo_post", 12'hB00, 32'h0000_0000);
        read_chk("cyc_hi_post", 12'hB80, 32'h0000_0001);

        // ---- minstret wrap at 2^64-1 ----
        drive(2'b01, 12'hB82, 32'hFFFF_FFFF); tick();
        drive(2'b01, 12'hB02, 32'hFFFF_FFFF); tick();
        read_chk("ins_lo_pre", 12'hB02, 32'hFFFF_FFFF);
        read_chk("ins_hi_pre", 12'hB82, 32'hFFFF_FFFF);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        read_chk("ins_lo_wrap", 12'hB02, 32'h0000_0000);
        read_chk("ins_hi_wrap", 12'hB82, 32'h0000_0000);

        // ---- Write beats retire; dropped write lets retire count ----
        drive(2'b01, 12'hB02, 32'h0000_0005);
        retire = 1'b1;
        tick();
        drive(2'b00, 12'hB02, 32'h0);
        #1;
        check("ins_write_wins", csr_rdata, 32'h0000_0005);
        tick();
        check("ins_retire", csr_rdata, 32'h0000_0006);
        drive(2'b01, 12'hB02, 32'h0000_0100);
        mret = 1'b1;
        tick();
        mret   = 1'b0;
        retire = 1'b0;
        read_chk("ins_dropped_write", 12'hB02, 32'h0000_0007);

        // ---- Idle cycles do not count retirement ----
        tick();
        tick();
        read_chk("ins_idle", 12'hB02, 32'h0000_0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
